// File: rtl/reduce_pkg.sv
// reduce_pkg: shared definitions for the streaming reduction unit.
//   - base-op encoding carried in mode[1:0], inversion flag in mode[INV_BIT]
//   - FSM state encoding used by reduce_gate_acc
//   - combine(): folds one beat term into the running accumulator
package reduce_pkg;

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;
    localparam int         INV_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // The reserved op code folds like AND.
    function automatic logic combine(input logic a, input logic b, input logic [1:0] op);
        logic r;
        case (op)
            MODE_OR:  r = a | b;
            MODE_XOR: r = a ^ b;
            default:  r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reduce_beat.sv
// reduce_beat: combinational reduction of one WIDTH-bit beat to a single bit.
// Ports:
//   data   - beat data
//   op     - base op (AND / OR / XOR; reserved code behaves as AND)
//   beat_r - reduced bit
module reduce_beat
    import reduce_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    output logic             beat_r
);

    always_comb begin
        beat_r = &data;
        case (op)
            MODE_OR:  beat_r = |data;
            MODE_XOR: beat_r = ^data;
            default:  beat_r = &data;
        endcase
    end

endmodule

// File: rtl/reduce_gate_acc.sv
// reduce_gate_acc: streams a packet of WIDTH-bit beats and reduces it to one
// bit with AND/OR/XOR, optionally inverted (NAND/NOR/XNOR).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   mode                  - op select, captured on the first beat of a packet
//   in_valid/in_ready     - beat handshake; in_data, in_last travel with it
//   out_valid/out_ready   - result handshake; out_bit, out_beats travel with it
//   busy                  - high while a packet is being accumulated or held
//   mode_err              - only with REDUCE_GATE_MODE_CHK_EN: packet started
//                           with the reserved op code
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready
// depends only on state and rst (never on out_ready), so a result and a new
// first beat can never transfer in the same cycle. Results are registered and
// stay stable while out_valid is high and out_ready is low.
// Configuration macro: REDUCE_GATE_MODE_CHK_EN (adds mode_err).
module reduce_gate_acc
    import reduce_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_beats,
    output logic             busy
`ifdef REDUCE_GATE_MODE_CHK_EN
    ,
    output logic             mode_err
`endif
);

    state_e           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       mode_q, mode_d;
    logic             out_bit_q, out_bit_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             beat_r;
    logic [1:0]       op_sel;
    logic             accept;

    // The first beat uses the live mode input; later beats use the captured one.
    assign op_sel = (state_q == IDLE) ? mode[1:0] : mode_q[1:0];

    reduce_beat #(.WIDTH(WIDTH)) u_beat (
        .data   (in_data),
        .op     (op_sel),
        .beat_r (beat_r)
    );

    assign in_ready  = !rst && (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_bit   = out_bit_q;
    assign out_beats = out_beats_q;

`ifdef REDUCE_GATE_MODE_CHK_EN
    logic err_q, err_d;
    assign mode_err = err_q;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        mode_d      = mode_q;
        out_bit_d   = out_bit_q;
        out_beats_d = out_beats_q;
`ifdef REDUCE_GATE_MODE_CHK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = mode;
                    acc_d   = beat_r;
                    count_d = CNT_W'(1);
`ifdef REDUCE_GATE_MODE_CHK_EN
                    err_d   = (mode[1:0] == MODE_RSV);
`endif
                    if (in_last) begin
                        state_d     = HOLD;
                        out_bit_d   = beat_r ^ mode[INV_BIT];
                        out_beats_d = CNT_W'(1);
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = combine(acc_q, beat_r, mode_q[1:0]);
                    count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                    if (in_last) begin
                        state_d     = HOLD;
                        out_bit_d   = acc_d ^ mode_q[INV_BIT];
                        out_beats_d = count_d;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            count_q     <= '0;
            mode_q      <= '0;
            out_bit_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            out_bit_q   <= out_bit_d;
            out_beats_q <= out_beats_d;
        end
    end

`ifdef REDUCE_GATE_MODE_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_reduce_gate_acc.sv
// Bench for reduce_gate_acc. Two instances share all inputs: dut (CNT_W=8)
// and dut_s (CNT_W=2) for the saturating beat counter.
module tb_reduce_gate_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid, out_bit, busy;
    logic [7:0] out_beats;
    logic       in_ready_s, out_valid_s, out_bit_s, busy_s;
    logic [1:0] out_beats_s;
`ifdef REDUCE_GATE_MODE_CHK_EN
    logic       mode_err, mode_err_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reduce_gate_acc #(.WIDTH(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_beats(out_beats), .busy(busy)
`ifdef REDUCE_GATE_MODE_CHK_EN
        , .mode_err(mode_err)
`endif
    );

    reduce_gate_acc #(.WIDTH(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_bit(out_bit_s), .out_beats(out_beats_s), .busy(busy_s)
`ifdef REDUCE_GATE_MODE_CHK_EN
        , .mode_err(mode_err_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one beat; it must be accepted on the next rising edge.
    task automatic send_beat(input logic [4:0] d, input logic l, input logic [2:0] m);
        mode     = m;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        check("in_ready_at_beat", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic b, input logic [7:0] beats);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_bit"},   out_bit,   b);
        check({tag, "_beats"}, out_beats, beats);
        check({tag, "_in_ready_low"}, in_ready, 1'b0);
    endtask

    task automatic pop_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_dropped"}, out_valid, 1'b0);
        check({tag, "_in_ready_back"}, in_ready,  1'b1);
    endtask

    initial begin
        rst = 1'b1; mode = 3'b000; in_valid = 1'b0; in_data = 5'b0;
        in_last = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_low", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_bit", out_bit,   1'b0);
        check("rst_out_beats", out_beats, 8'd0);
        check("rst_busy", busy,      1'b0);
`ifdef REDUCE_GATE_MODE_CHK_EN
        check("rst_mode_err", mode_err, 1'b0);
`endif

        // 1: single-beat AND
        send_beat(5'b11111, 1'b1, 3'b000);
        expect_result("and1", 1'b1, 8'd1);
        check("and1_busy", busy, 1'b1);
        pop_result("and1");
        check("idle_keeps_bit", out_bit, 1'b1);
        check("idle_keeps_beats", out_beats, 8'd1);
        check("idle_busy", busy, 1'b0);
        send_beat(5'b00101, 1'b1, 3'b000);
        expect_result("and0", 1'b0, 8'd1);
        pop_result("and0");

        // 2: multi-beat OR, mode changed mid-packet, with a stall
        send_beat(5'b00000, 1'b0, 3'b001);
        check("or_busy_accum", busy, 1'b1);
        send_beat(5'b00000, 1'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("stall_no_valid", out_valid, 1'b0);
        check("stall_busy", busy, 1'b1);
        send_beat(5'b00100, 1'b1, 3'b000);
        expect_result("or3", 1'b1, 8'd3);
        pop_result("or3");

        // 3: XNOR parity 1^0^1 = 0 -> inverted 1
        send_beat(5'b00001, 1'b0, 3'b110);
        send_beat(5'b00011, 1'b0, 3'b110);
        send_beat(5'b00111, 1'b1, 3'b110);
        expect_result("xnor", 1'b1, 8'd3);
        pop_result("xnor");

        // 4: backpressure; XOR of 10110 (1) and 00000 (0) = 1. A beat offered
        // during HOLD must not be taken.
        send_beat(5'b10110, 1'b0, 3'b010);
        send_beat(5'b00000, 1'b1, 3'b010);
        in_valid = 1'b1; in_data = 5'b00000; in_last = 1'b1; mode = 3'b000;
        for (int i = 0; i < 4; i++) begin
            expect_result("hold", 1'b1, 8'd2);
            @(posedge clk);
            #1;
        end
        pop_result("hold");
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk);
        #1;
        check("hold_no_stray_accept", busy, 1'b0);
        check("hold_bit_kept", out_bit, 1'b1);

        // 5: counter saturation on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            send_beat(5'b11111, (i == 4), 3'b000);
        end
        check("sat_valid", out_valid_s, 1'b1);
        check("sat_beats", out_beats_s, 2'd3);
        check("sat_bit", out_bit_s, 1'b1);
        expect_result("nosat", 1'b1, 8'd5);
        pop_result("sat");

        // 6: reset mid-packet aborts without a result
        send_beat(5'b11111, 1'b0, 3'b001);
        send_beat(5'b11111, 1'b0, 3'b001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_bit", out_bit, 1'b0);
        check("abort_beats", out_beats, 8'd0);
        @(posedge clk);
        #1;
        check("abort_still_idle", out_valid, 1'b0);
        send_beat(5'b10000, 1'b1, 3'b010);
        expect_result("post_rst", 1'b1, 8'd1);
`ifdef REDUCE_GATE_MODE_CHK_EN
        check("post_rst_err", mode_err, 1'b0);
`endif
        pop_result("post_rst");

        // Reserved mode behaves as AND: 11111 & 01111 = 0
        send_beat(5'b11111, 1'b0, 3'b011);
        send_beat(5'b01111, 1'b1, 3'b000);
        expect_result("rsv", 1'b0, 8'd2);
`ifdef REDUCE_GATE_MODE_CHK_EN
        check("rsv_err", mode_err, 1'b1);
`endif
        pop_result("rsv");
        send_beat(5'b00010, 1'b1, 3'b101);
        expect_result("nor", 1'b0, 8'd1);
`ifdef REDUCE_GATE_MODE_CHK_EN
        check("err_cleared", mode_err, 1'b0);
`endif
        pop_result("nor");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
